// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues one word-address read at a time, buffers a
// response that arrives while decode is stalled, and squashes stale responses after a redirect.
module instr_fetch #(
  parameter int          ADDR_WIDTH = 10,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_rvalid,
  input  logic [31:0]           imem_rdata,
  output logic [31:0]           if_id_reg,
  output logic [ADDR_WIDTH-1:0] if_id_pc,
  output logic [31:0]           fetch_count
);

  localparam logic [ADDR_WIDTH-1:0] RST_PC = ADDR_WIDTH'(RESET_PC);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]           ir_q, ir_d;
  logic [ADDR_WIDTH-1:0] ipc_q, ipc_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [31:0]           buf_q, buf_d;
  logic                  deliver;
  logic [31:0]           dword;

  // Gated by reset so no request escapes while the FSM is held in REQ.
  assign imem_req    = (state_q == S_REQ) && !redirect_valid && !reset;
  assign imem_addr   = pc_q;
  assign if_id_reg   = ir_q;
  assign if_id_pc    = ipc_q;
  assign fetch_count = cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_REQ;
      pc_q    <= RST_PC;
      ir_q    <= '0;
      ipc_q   <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ipc_q   <= ipc_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = stall ? ir_q : 32'h0;
    ipc_d   = ipc_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    deliver = 1'b0;
    dword   = 32'h0;

    if (redirect_valid) begin
      pc_d  = redirect_pc;
      ir_d  = 32'h0;
      buf_d = 32'h0;
      // An in-flight response still has to be swallowed before the next request.
      if ((state_q == S_WAIT || state_q == S_DROP) && !imem_rvalid) state_d = S_DROP;
      else                                                          state_d = S_REQ;
    end else begin
      case (state_q)
        S_REQ:  if (imem_req) state_d = S_WAIT;
        S_WAIT: if (imem_rvalid) begin
                  if (stall) begin
                    buf_d   = imem_rdata;
                    state_d = S_HOLD;
                  end else begin
                    deliver = 1'b1;
                    dword   = imem_rdata;
                  end
                end
        S_HOLD: if (!stall) begin
                  deliver = 1'b1;
                  dword   = buf_q;
                end
        S_DROP: if (imem_rvalid) state_d = S_REQ;
        default: state_d = S_REQ;
      endcase
    end

    if (deliver) begin
      ir_d    = dword;
      ipc_d   = pc_q;
      pc_d    = pc_q + ADDR_WIDTH'(1);
      cnt_d   = cnt_q + 32'd1;
      state_d = S_REQ;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a latency-programmable memory responder.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [9:0]  redirect_pc;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_reg;
  logic [9:0]  if_id_pc;
  logic [31:0] fetch_count;

  logic [31:0] mem [0:1023];
  int          lat = 1;
  int          rcnt = 0;
  logic [9:0]  raddr = '0;
  int          errors = 0;
  int          checks = 0;

  instr_fetch #(.ADDR_WIDTH(10), .RESET_PC(0)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_id_reg(if_id_reg), .if_id_pc(if_id_pc), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Memory: a request seen in cycle k returns rvalid in cycle k+lat.
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (reset) rcnt = 0;
      else if (imem_req) begin
        raddr = imem_addr;
        rcnt  = lat;
      end
      @(posedge clk);
      #2;
      if (rcnt > 0) begin
        rcnt = rcnt - 1;
        imem_rvalid = (rcnt == 0);
        imem_rdata  = (rcnt == 0) ? mem[raddr] : 32'h0;
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++; if (if_id_reg !== 32'h0) begin errors++; $display("FAIL rst_ir: got %h expected %h", if_id_reg, 32'h0); end
    checks++; if (if_id_pc !== 10'h0) begin errors++; $display("FAIL rst_pc: got %h expected %h", if_id_pc, 10'h0); end
    checks++; if (fetch_count !== 32'h0) begin errors++; $display("FAIL rst_cnt: got %h expected %h", fetch_count, 32'h0); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", imem_req); end
    checks++; if (imem_addr !== 10'h0) begin errors++; $display("FAIL rst_addr: got %h expected %h", imem_addr, 10'h0); end
    reset = 1'b0;
  endtask

  task automatic test_sequential();
    tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL seq_wait_req: got %b expected 0", imem_req); end
    tick();
    checks++; if (if_id_reg !== 32'h2A000001) begin errors++; $display("FAIL seq_ir0: got %h expected %h", if_id_reg, 32'h2A000001); end
    checks++; if (if_id_pc !== 10'h0) begin errors++; $display("FAIL seq_pc0: got %h expected %h", if_id_pc, 10'h0); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 10'h1) begin errors++; $display("FAIL seq_req1: got %b/%h expected 1/001", imem_req, imem_addr); end
    tick();
    checks++; if (if_id_reg !== 32'h0) begin errors++; $display("FAIL seq_noop: got %h expected %h", if_id_reg, 32'h0); end
    checks++; if (if_id_pc !== 10'h0) begin errors++; $display("FAIL seq_noop_pc: got %h expected %h", if_id_pc, 10'h0); end
    tick();
    checks++; if (if_id_reg !== 32'h2A000002) begin errors++; $display("FAIL seq_ir1: got %h expected %h", if_id_reg, 32'h2A000002); end
    checks++; if (if_id_pc !== 10'h1) begin errors++; $display("FAIL seq_pc1: got %h expected %h", if_id_pc, 10'h1); end
    checks++; if (fetch_count !== 32'd2) begin errors++; $display("FAIL seq_cnt: got %0d expected 2", fetch_count); end
  endtask

  task automatic test_stall_capture();
    tick();
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 10'h3) begin errors++; $display("FAIL stl_req3: got %b/%h expected 1/003", imem_req, imem_addr); end
    tick();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (if_id_reg !== 32'h0 || if_id_pc !== 10'h2) begin errors++; $display("FAIL stl_hold%0d: got %h/%h expected 00000000/002", i, if_id_reg, if_id_pc); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stl_noreq%0d: got %b expected 0", i, imem_req); end
    end
    stall = 1'b0;
    tick();
    checks++; if (if_id_reg !== 32'hA5A5A5A5) begin errors++; $display("FAIL stl_ir: got %h expected %h", if_id_reg, 32'hA5A5A5A5); end
    checks++; if (if_id_pc !== 10'h3) begin errors++; $display("FAIL stl_pc: got %h expected %h", if_id_pc, 10'h3); end
    checks++; if (imem_addr !== 10'h4 || imem_req !== 1'b1) begin errors++; $display("FAIL stl_next: got %b/%h expected 1/004", imem_req, imem_addr); end
    checks++; if (fetch_count !== 32'd4) begin errors++; $display("FAIL stl_cnt: got %0d expected 4", fetch_count); end
  endtask

  task automatic test_redirect_drop();
    lat = 3;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 10'h100;
    tick();
    redirect_valid = 1'b0;
    checks++; if (imem_req !== 1'b0 || imem_addr !== 10'h100) begin errors++; $display("FAIL drp_enter: got %b/%h expected 0/100", imem_req, imem_addr); end
    checks++; if (if_id_reg !== 32'h0) begin errors++; $display("FAIL drp_ir: got %h expected %h", if_id_reg, 32'h0); end
    tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL drp_stay: got %b expected 0", imem_req); end
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 10'h100) begin errors++; $display("FAIL drp_exit: got %b/%h expected 1/100", imem_req, imem_addr); end
    checks++; if (fetch_count !== 32'd4 || if_id_reg !== 32'h0) begin errors++; $display("FAIL drp_cnt: got %0d/%h expected 4/00000000", fetch_count, if_id_reg); end
    lat = 1;
  endtask

  task automatic test_redirect_stall_rvalid();
    tick();
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 10'h3FF;
    tick();
    checks++; if (if_id_reg !== 32'h0) begin errors++; $display("FAIL rsr_ir: got %h expected %h", if_id_reg, 32'h0); end
    checks++; if (imem_addr !== 10'h3FF) begin errors++; $display("FAIL rsr_pc: got %h expected %h", imem_addr, 10'h3FF); end
    checks++; if (fetch_count !== 32'd4) begin errors++; $display("FAIL rsr_cnt: got %0d expected 4", fetch_count); end
    stall          = 1'b0;
    redirect_valid = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rsr_state: got %b expected 1", imem_req); end
  endtask

  task automatic test_wrap();
    tick();
    tick();
    checks++; if (if_id_reg !== 32'h500003FF || if_id_pc !== 10'h3FF) begin errors++; $display("FAIL wrp_ir: got %h/%h expected 500003ff/3ff", if_id_reg, if_id_pc); end
    checks++; if (imem_addr !== 10'h000 || imem_req !== 1'b1) begin errors++; $display("FAIL wrp_addr: got %b/%h expected 1/000", imem_req, imem_addr); end
    checks++; if (fetch_count !== 32'd5) begin errors++; $display("FAIL wrp_cnt: got %0d expected 5", fetch_count); end
  endtask

  task automatic test_reset_in_wait();
    lat = 3;
    tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rw_wait: got %b expected 0", imem_req); end
    reset = 1'b1;
    #1;
    checks++; if (if_id_reg !== 32'h0 || if_id_pc !== 10'h0) begin errors++; $display("FAIL rw_ir: got %h/%h expected 00000000/000", if_id_reg, if_id_pc); end
    checks++; if (fetch_count !== 32'h0) begin errors++; $display("FAIL rw_cnt: got %0d expected 0", fetch_count); end
    checks++; if (imem_req !== 1'b0 || imem_addr !== 10'h0) begin errors++; $display("FAIL rw_req: got %b/%h expected 0/000", imem_req, imem_addr); end
    tick();
    tick();
    reset = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 10'h0) begin errors++; $display("FAIL rw_restart: got %b/%h expected 1/000", imem_req, imem_addr); end
    for (int i = 0; i < 4; i++) tick();
    checks++; if (if_id_reg !== 32'h2A000001 || if_id_pc !== 10'h0) begin errors++; $display("FAIL rw_ir0: got %h/%h expected 2a000001/000", if_id_reg, if_id_pc); end
    checks++; if (fetch_count !== 32'd1) begin errors++; $display("FAIL rw_cnt1: got %0d expected 1", fetch_count); end
    lat = 1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h5000_0000 | i;
    mem[0] = 32'h2A000001;
    mem[1] = 32'h2A000002;
    mem[3] = 32'hA5A5A5A5;
    reset          = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    test_reset();
    test_sequential();
    test_stall_capture();
    test_redirect_drop();
    test_redirect_stall_rvalid();
    test_wrap();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
